// File: rtl/m_mem_ctrl.sv
// M-stage data-memory access controller: sequences loads/stores onto a req/gnt/rvalid bus.
// Optional MEM_ALIGN_EXC_EN: misaligned accesses raise AdEL/AdES instead of issuing a request.
module m_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_MemOp,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WData,
  input  logic        M_Hold,
  output logic        M_Stall,
  output logic [31:0] M_RData,
  output logic        M_BusErr,
`ifdef MEM_ALIGN_EXC_EN
  output logic [4:0]  M_ExcCode,
`endif
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [3:0] OP_SW  = 4'd1;
  localparam logic [3:0] OP_SH  = 4'd2;
  localparam logic [3:0] OP_SB  = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LH  = 4'd5;
  localparam logic [3:0] OP_LHU = 4'd6;
  localparam logic [3:0] OP_LB  = 4'd7;
  localparam logic [3:0] OP_LBU = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       lo_q, lo_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_byteen_q, bus_byteen_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             bus_err_q, bus_err_d;
`ifdef MEM_ALIGN_EXC_EN
  logic [4:0]       exc_q, exc_d;
  logic             misalign;
`endif

  logic        op_valid;
  logic        op_store;
  logic        timeout;
  logic [3:0]  cap_byteen;
  logic [31:0] cap_wdata;

  assign op_valid = (M_MemOp >= OP_SW) && (M_MemOp <= OP_LBU);
  assign op_store = (M_MemOp >= OP_SW) && (M_MemOp <= OP_SB);
  assign timeout  = (cnt_q == CNT_LAST);

  // Select, then sign/zero-extend the addressed lane of the returned word.
  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = 16'(w >> {lo[1], 4'b0000});
    b = 8'(w >> {lo, 3'b000});
    case (op)
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0000, h};
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h000000, b};
      default: load_ext = w;
    endcase
  endfunction

  // Lane enables and lane-shifted store data for the op being captured.
  always_comb begin
    cap_byteen = 4'b0000;
    cap_wdata  = 32'h0000_0000;
    case (M_MemOp)
      OP_SW: begin
        cap_byteen = 4'b1111;
        cap_wdata  = M_WData;
      end
      OP_SH: begin
        cap_byteen = M_Addr[1] ? 4'b1100 : 4'b0011;
        cap_wdata  = 32'(M_WData[15:0]) << {M_Addr[1], 4'b0000};
      end
      OP_SB: begin
        cap_byteen = 4'b0001 << M_Addr[1:0];
        cap_wdata  = 32'(M_WData[7:0]) << {M_Addr[1:0], 3'b000};
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  always_comb begin
    misalign = 1'b0;
    case (M_MemOp)
      OP_SW, OP_LW:         misalign = (M_Addr[1:0] != 2'b00);
      OP_SH, OP_LH, OP_LHU: misalign = M_Addr[0];
      default:              misalign = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    lo_d         = lo_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_byteen_d = bus_byteen_q;
    bus_wdata_d  = bus_wdata_q;
    rdata_d      = rdata_q;
    bus_err_d    = bus_err_q;
`ifdef MEM_ALIGN_EXC_EN
    exc_d        = exc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d  = M_MemOp;
          lo_d  = M_Addr[1:0];
          cnt_d = '0;
`ifdef MEM_ALIGN_EXC_EN
          if (misalign) begin
            state_d = S_DONE;
            rdata_d = 32'h0000_0000;
            exc_d   = op_store ? 5'd5 : 5'd4;
          end else begin
`endif
            state_d      = S_REQ;
            bus_req_d    = 1'b1;
            bus_we_d     = op_store;
            bus_addr_d   = {M_Addr[31:2], 2'b00};
            bus_byteen_d = cap_byteen;
            bus_wdata_d  = cap_wdata;
`ifdef MEM_ALIGN_EXC_EN
          end
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = bus_we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          rdata_d = load_ext(op_q, lo_q, bus_rdata);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!M_Hold) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
          exc_d     = 5'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog bounds REQ+WAIT to TIMEOUT_CYC cycles; it wins over a same-cycle response.
    if ((state_q == S_REQ || state_q == S_WAIT) && timeout) begin
      state_d   = S_DONE;
      bus_req_d = 1'b0;
      bus_err_d = 1'b1;
      rdata_d   = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= 4'd0;
      lo_q         <= 2'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_byteen_q <= 4'b0000;
      bus_wdata_q  <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      bus_err_q    <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
      exc_q        <= 5'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_byteen_q <= bus_byteen_d;
      bus_wdata_q  <= bus_wdata_d;
      rdata_q      <= rdata_d;
      bus_err_q    <= bus_err_d;
`ifdef MEM_ALIGN_EXC_EN
      exc_q        <= exc_d;
`endif
    end
  end

  assign M_Stall    = ((state_q == S_IDLE) && op_valid) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign M_RData    = rdata_q;
  assign M_BusErr   = bus_err_q;
`ifdef MEM_ALIGN_EXC_EN
  assign M_ExcCode  = exc_q;
`endif
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_byteen_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Scoreboard bench for m_mem_ctrl: stimulus pushes expected bus requests and results,
// a negedge monitor pops and compares them. Define MEM_ALIGN_EXC_EN to cover alignment traps.
module tb_m_mem_ctrl;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_SH   = 4'd2;
  localparam logic [3:0] OP_SB   = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_LH   = 4'd5;
  localparam logic [3:0] OP_LHU  = 4'd6;
  localparam logic [3:0] OP_LB   = 4'd7;
  localparam logic [3:0] OP_LBU  = 4'd8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    logic [4:0]  exc;
  } res_t;

  logic        clk;
  logic        reset;
  logic [3:0]  M_MemOp;
  logic [31:0] M_Addr;
  logic [31:0] M_WData;
  logic        M_Hold;
  logic        M_Stall;
  logic [31:0] M_RData;
  logic        M_BusErr;
`ifdef MEM_ALIGN_EXC_EN
  logic [4:0]  M_ExcCode;
`endif
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_count = 0;
  int   exp_hs = 0;
  bit   mon_en = 0;
  bit   prev_stall = 0;
  bus_t bus_q[$];
  res_t res_q[$];

  m_mem_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .M_MemOp(M_MemOp), .M_Addr(M_Addr), .M_WData(M_WData), .M_Hold(M_Hold),
    .M_Stall(M_Stall), .M_RData(M_RData), .M_BusErr(M_BusErr),
`ifdef MEM_ALIGN_EXC_EN
    .M_ExcCode(M_ExcCode),
`endif
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bus_t mk_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                                  input logic [31:0] wd);
    bus_t b;
    b.we = we; b.addr = a; b.be = be; b.wd = wd;
    return b;
  endfunction

  function automatic res_t mk_res(input logic err, input logic chk_rd, input logic [31:0] rd,
                                  input logic [4:0] exc);
    res_t r;
    r.err = err; r.chk_rd = chk_rd; r.rd = rd; r.exc = exc;
    return r;
  endfunction

  // Monitor: bus handshakes and DONE entry (falling M_Stall) are checked against the queues.
  initial begin
    bus_t eb;
    res_t er;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (bus_req && bus_gnt) begin
          hs_count++;
          if (bus_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL bus_unexpected: handshake at addr 0x%08h, none expected", bus_addr);
          end else begin
            eb = bus_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(eb.we));
            chk("bus_addr", bus_addr, eb.addr);
            chk("bus_byteen", 32'(bus_byteen), 32'(eb.be));
            chk("bus_wdata", bus_wdata, eb.wd);
          end
        end
        if (prev_stall && !M_Stall) begin
          if (res_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL res_unexpected: completion with rdata 0x%08h, none expected", M_RData);
          end else begin
            er = res_q.pop_front();
            chk("M_BusErr", 32'(M_BusErr), 32'(er.err));
            if (er.chk_rd) chk("M_RData", M_RData, er.rd);
`ifdef MEM_ALIGN_EXC_EN
            chk("M_ExcCode", 32'(M_ExcCode), 32'(er.exc));
`endif
          end
        end
        prev_stall = M_Stall;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Issue one op, play the slave, then hold DONE for 'hold' extra cycles and retire it.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input int hold, input bit push_bus,
                        input bus_t eb, input res_t er, input int exp_stall, input int exp_req);
    int stalls = 0;
    int rq = 0;
    int wq = 0;
    int bad_addr = 0;
    bit granted = 0;
    bit done = 0;
    @(negedge clk);
    M_MemOp = op; M_Addr = addr; M_WData = wdata; M_Hold = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdata;
    if (push_bus) begin bus_q.push_back(eb); exp_hs++; end
    res_q.push_back(er);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!M_Stall) begin done = 1; break; end
      stalls++;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (bus_req) begin
        if (bus_addr !== eb.addr) bad_addr++;
        if (rq == gnt_dly) begin bus_gnt = 1'b1; granted = 1; end
        rq++;
      end else if (granted) begin
        if (wq == rv_dly) bus_rvalid = 1'b1;
        wq++;
      end
      if (c == 1) begin M_Addr = ~addr; M_WData = ~wdata; end
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_stall_cyc"}, stalls, exp_stall);
    chk({nm, "_req_cyc"}, rq, exp_req);
    chk({nm, "_addr_stable"}, bad_addr, 32'd0);
    // Stray responses while in DONE must not start another transaction.
    bus_gnt = 1'b1; bus_rvalid = 1'b1;
    if (hold > 0) M_Hold = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk({nm, "_hold_stall"}, 32'(M_Stall), 32'd0);
      chk({nm, "_hold_req"}, 32'(bus_req), 32'd0);
      if (h == hold - 1) M_Hold = 1'b0;
    end
    M_MemOp = OP_NONE;
    @(negedge clk);
    #1;
    chk({nm, "_idle_req"}, 32'(bus_req), 32'd0);
    chk({nm, "_idle_err"}, 32'(M_BusErr), 32'd0);
`ifdef MEM_ALIGN_EXC_EN
    chk({nm, "_idle_exc"}, 32'(M_ExcCode), 32'd0);
`endif
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; M_MemOp = OP_NONE; M_Addr = '0; M_WData = '0; M_Hold = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_byteen", 32'(bus_byteen), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", M_RData, 32'd0);
    chk("rst_err", 32'(M_BusErr), 32'd0);
    chk("rst_stall", 32'(M_Stall), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    run_op("sb", OP_SB, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0, 0, 1,
           mk_bus(1'b1, 32'h0000_1000, 4'b1000, 32'hAB00_0000), mk_res(1'b0, 1'b0, 32'h0, 5'd0), 2, 1);
    run_op("lh", OP_LH, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, 0, 1,
           mk_bus(1'b0, 32'h0000_2000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'hFFFF_8001, 5'd0), 3, 1);
    run_op("lhu", OP_LHU, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, 0, 1,
           mk_bus(1'b0, 32'h0000_2000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'h0000_8001, 5'd0), 3, 1);
    run_op("lb_slow", OP_LB, 32'h0000_2001, 32'h0, 4, 0, 32'h0000_7F00, 0, 1,
           mk_bus(1'b0, 32'h0000_2000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'h0000_007F, 5'd0), 7, 5);
    run_op("sw_hold", OP_SW, 32'h0000_4000, 32'hDEAD_BEEF, 0, 0, 32'h0, 3, 1,
           mk_bus(1'b1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF), mk_res(1'b0, 1'b0, 32'h0, 5'd0), 2, 1);
    run_op("sh_hi", OP_SH, 32'h0000_5002, 32'h1234_ABCD, 0, 0, 32'h0, 0, 1,
           mk_bus(1'b1, 32'h0000_5000, 4'b1100, 32'hABCD_0000), mk_res(1'b0, 1'b0, 32'h0, 5'd0), 2, 1);
    run_op("lbu", OP_LBU, 32'h0000_6003, 32'h0, 0, 0, 32'h8000_0000, 1, 1,
           mk_bus(1'b0, 32'h0000_6000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'h0000_0080, 5'd0), 3, 1);
    run_op("lb_neg", OP_LB, 32'h0000_6003, 32'h0, 0, 0, 32'h8000_0000, 0, 1,
           mk_bus(1'b0, 32'h0000_6000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'hFFFF_FF80, 5'd0), 3, 1);
    run_op("lw_rv2", OP_LW, 32'h0000_7000, 32'h0, 0, 2, 32'h1234_5678, 0, 1,
           mk_bus(1'b0, 32'h0000_7000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'h1234_5678, 5'd0), 5, 1);
    run_op("sb_l1", OP_SB, 32'h0000_7001, 32'h0000_0055, 1, 0, 32'h0, 0, 1,
           mk_bus(1'b1, 32'h0000_7000, 4'b0010, 32'h0000_5500), mk_res(1'b0, 1'b0, 32'h0, 5'd0), 3, 2);
    run_op("to_req", OP_LW, 32'h0000_8000, 32'h0, 100, 0, 32'hFFFF_FFFF, 0, 0,
           mk_bus(1'b0, 32'h0000_8000, 4'b0000, 32'h0), mk_res(1'b1, 1'b1, 32'h0, 5'd0), 9, 8);
    run_op("to_wait", OP_LH, 32'h0000_9002, 32'h0, 2, 100, 32'hFFFF_FFFF, 1, 1,
           mk_bus(1'b0, 32'h0000_9000, 4'b0000, 32'h0), mk_res(1'b1, 1'b1, 32'h0, 5'd0), 9, 3);
`ifdef MEM_ALIGN_EXC_EN
    run_op("adel", OP_LW, 32'h0000_3002, 32'h0, 0, 0, 32'h0, 0, 0,
           mk_bus(1'b0, 32'h0000_3000, 4'b0000, 32'h0), mk_res(1'b0, 1'b1, 32'h0, 5'd4), 1, 0);
    run_op("ades", OP_SH, 32'h0000_3001, 32'h0000_BEEF, 0, 0, 32'h0, 0, 0,
           mk_bus(1'b1, 32'h0000_3000, 4'b0000, 32'h0), mk_res(1'b0, 1'b0, 32'h0, 5'd5), 1, 0);
`endif

    // Reset pulled while a load waits for rvalid.
    @(negedge clk);
    mon_en = 1'b0;
    M_MemOp = OP_LW; M_Addr = 32'h0000_A000; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    #1;
    bus_gnt = 1'b1;
    @(negedge clk);
    #1;
    bus_gnt = 1'b0;
    chk("rw_wait_stall", 32'(M_Stall), 32'd1);
    chk("rw_wait_req", 32'(bus_req), 32'd0);
    reset = 1'b0;
    M_MemOp = OP_NONE;
    @(negedge clk);
    #1;
    reset = 1'b1;
    chk("rw_req", 32'(bus_req), 32'd0);
    chk("rw_stall", 32'(M_Stall), 32'd0);
    chk("rw_addr", bus_addr, 32'd0);
    bus_rvalid = 1'b1;
    @(negedge clk);
    #1;
    bus_rvalid = 1'b0;
    chk("rw_late_rvalid_rdata", M_RData, 32'd0);
    chk("rw_late_rvalid_stall", 32'(M_Stall), 32'd0);
    M_MemOp = OP_SB;
    #1;
    chk("rw_stall_follows_op", 32'(M_Stall), 32'd1);
    M_MemOp = 4'd12;
    #1;
    chk("rw_stall_op_invalid", 32'(M_Stall), 32'd0);
    M_MemOp = OP_NONE;
    @(negedge clk);
    mon_en = 1'b1;

    run_op("sw_post", OP_SW, 32'h0000_B003, 32'h0102_0304, 0, 0, 32'h0, 0, 1,
           mk_bus(1'b1, 32'h0000_B000, 4'b1111, 32'h0102_0304), mk_res(1'b0, 1'b0, 32'h0, 5'd0), 2, 1);

    repeat (3) @(negedge clk);
    #5;
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("res_q_drained", res_q.size(), 32'd0);
    chk("handshake_count", hs_count, exp_hs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/m_mem_ctrl.md
Name: m_mem_ctrl

Overview:
- M-stage data-memory access controller. It sequences each load/store of the pipeline onto a req/gnt/rvalid data bus.
- Generates byte enables and lane-shifted store data, and aligns/extends load data for W.
- Holds the pipeline stall while a bus transaction is outstanding. A watchdog aborts hung transactions.

Parameters:
TIMEOUT_CYC, 64, cycles spent in REQ+WAIT before abort; legal range 2..1024
CNT_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
M_MemOp  input  4  0 none, 1 sw, 2 sh, 3 sb, 4 lw, 5 lh, 6 lhu, 7 lb, 8 lbu; 9-15 treated as none
M_Addr  input  32  byte address from ALU
M_WData  input  32  forwarded store data (low bytes significant for sh/sb)
M_Hold  input  1  external pipeline freeze (other hazards); M instruction stays in place
M_Stall  output  1  freeze F/D/E/M, bubble W
M_RData  output  32  aligned, extended load result; valid while state==DONE
M_BusErr  output  1  1 in DONE when the transaction timed out
bus_req  output  1  request valid (registered)
bus_we  output  1  1 store, 0 load (registered)
bus_addr  output  32  {M_Addr[31:2],2'b00} (registered)
bus_byteen  output  4  lane enables; 4'b0000 for loads (registered)
bus_wdata  output  32  lane-shifted store data (registered)
bus_gnt  input  1  slave accepts request this cycle
bus_rvalid  input  1  read data valid this cycle
bus_rdata  input  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state=IDLE, counter=0, all registered outputs 0, M_RData=0, M_BusErr=0.
- IDLE:
  - If M_MemOp valid, capture op, addr[1:0], byteen, wdata into bus registers, then go to REQ.
  - Byteen: sw 1111; sh 0011/1100 by addr[1]; sb one-hot 0001<<addr[1:0].
  - Wdata: sh data[15:0]<<16*addr[1]; sb data[7:0]<<8*addr[1:0]; unused lanes 0.
- REQ:
  - bus_req=1, held stable until gnt.
  - On bus_gnt: store goes to DONE; load goes to WAIT. bus_req drops next cycle.
- WAIT:
  - On bus_rvalid, capture extended data into M_RData and go to DONE.
  - lw: word. lh/lhu: halfword at addr[1], sign/zero extended. lb/lbu: byte at addr[1:0], sign/zero extended.
  - rvalid in the same cycle as gnt is not legal; rvalid outside WAIT is ignored.
- DONE:
  - Stay while M_Hold=1, so the bus is not re-issued.
  - When M_Hold=0, go to IDLE. The pipeline advances at this edge.
- M_Stall (combinational) = (state==IDLE && op valid) || state==REQ || state==WAIT. It is 0 in DONE and for op none.
- Latency:
  - Store, gnt in the first REQ cycle: stall for 2 cycles, DONE on cycle 3.
  - Load, rvalid 1 cycle after gnt: DONE on cycle 4.
- Timeout:
  - Counter clears on IDLE to REQ and increments each REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYC: drop bus_req, go to DONE, M_BusErr=1, M_RData=0.
  - A late gnt/rvalid after abort is ignored.
- M_BusErr clears on leaving DONE.
- Back-to-back ops: DONE to IDLE, then the new op is captured the next cycle. Minimum is 1 idle bus cycle between transactions.
- Reset mid-transaction: at the reset edge, go to IDLE and clear bus_req/outputs next cycle. Outstanding responses are ignored.
- Address and data are taken only at capture; changes to M_* during REQ/WAIT are ignored.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Adds output M_ExcCode [4:0].
  - Misaligned accesses (lw/sw addr[1:0]!=0, lh/lhu/sh addr[0]!=0) never issue bus_req.
  - IDLE goes directly to DONE with M_ExcCode=4 for AdEL (loads) or 5 for AdES (stores), and M_RData=0.
  - M_ExcCode is 0 otherwise and clears on leaving DONE.
- Not defined:
  - No port is added.
  - Low address bits are used as given: sw/lw ignore addr[1:0]; sh/lh ignore addr[0].

Test Plan:
- sb addr=0x1003 data=0x000000AB, gnt on first REQ cycle -> bus_byteen=1000, bus_wdata=0xAB000000, bus_addr=0x1000, bus_we=1, stall 2 cycles, then DONE.
- lh addr=0x2002, rdata=0x8001_1234, rvalid 1 cycle after gnt -> M_RData=0xFFFF8001; lhu same -> 0x00008001; stall 3 cycles.
- lb addr=0x2001 rdata=0x00007F00 with gnt delayed 5 cycles -> bus_req held 5 cycles with address stable, M_RData=0x0000007F.
- TIMEOUT_CYC=8, no gnt -> bus_req drops after 8 REQ cycles, M_BusErr=1 for one DONE cycle, M_RData=0, then IDLE; a gnt arriving later is ignored.
- sw in DONE with M_Hold=1 for 3 cycles -> single bus transaction, DONE held 3 cycles; reset=0 during WAIT -> next cycle state IDLE, bus_req=0, M_Stall follows M_MemOp.
- MEM_ALIGN_EXC_EN defined, lw addr=0x3002 -> no bus_req, M_ExcCode=4 in DONE; sh addr=0x3001 -> M_ExcCode=5.
